// File: rtl/filter_pkg.sv
// Shared types and constants for the filter MAC scheduling blocks.
package filter_pkg;

    localparam int MAC_IDX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    typedef enum logic {
        SRC_FIR = 1'b0,
        SRC_LMS = 1'b1
    } src_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every DIV enabled clock cycles.
module sample_tick_gen #(
    parameter int DIV = 450
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_MAX) cnt <= '0;
            else                cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/mac_scheduler.sv
// Round-robin scheduler sharing one pipelined MAC between FIR and LMS bursts,
// paced by a sample-rate tick with a sticky overrun flag.
module mac_scheduler
    import filter_pkg::*;
#(
    parameter int DIV       = 450,
    parameter int NTAPS_FIR = 32,
    parameter int NTAPS_LMS = 16,
    parameter int LAT       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic                 sample_tick,
    input  logic                 fir_req,
    input  logic                 lms_req,
    output logic                 fir_gnt,
    output logic                 lms_gnt,
    output logic                 mac_valid,
    output logic [MAC_IDX_W-1:0] mac_idx,
    output logic                 mac_clr,
    output logic                 mac_last,
    output logic                 fir_done,
    output logic                 lms_done,
    output logic                 overrun
);

    localparam logic [MAC_IDX_W-1:0] FIR_LAST   = MAC_IDX_W'(NTAPS_FIR - 1);
    localparam logic [MAC_IDX_W-1:0] LMS_LAST   = MAC_IDX_W'(NTAPS_LMS - 1);
    localparam logic [2:0]           DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    sched_state_t         state, state_nxt;
    src_t                 owner, owner_nxt;
    src_t                 last_srv, last_srv_nxt;
    logic [MAC_IDX_W-1:0] idx, idx_nxt;
    logic [MAC_IDX_W-1:0] idx_last;
    logic [2:0]           dcnt, dcnt_nxt;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (sample_tick)
    );

    assign idx_last = (owner == SRC_LMS) ? LMS_LAST : FIR_LAST;

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_srv_nxt = last_srv;
        idx_nxt      = idx;
        dcnt_nxt     = dcnt;
        mac_valid    = 1'b0;
        mac_idx      = '0;
        mac_clr      = 1'b0;
        mac_last     = 1'b0;
        fir_gnt      = (state != ST_IDLE) && (owner == SRC_FIR);
        lms_gnt      = (state != ST_IDLE) && (owner == SRC_LMS);
        fir_done     = en && (state == ST_DONE) && (owner == SRC_FIR);
        lms_done     = en && (state == ST_DONE) && (owner == SRC_LMS);

        if (en && state == ST_BURST) begin
            mac_valid = 1'b1;
            mac_idx   = idx;
            mac_clr   = (idx == '0);
            mac_last  = (idx == idx_last);
        end

        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (fir_req || lms_req) begin
                        // On a tie the requester not served last wins
                        if (fir_req && lms_req)
                            owner_nxt = (last_srv == SRC_FIR) ? SRC_LMS : SRC_FIR;
                        else
                            owner_nxt = fir_req ? SRC_FIR : SRC_LMS;
                        last_srv_nxt = owner_nxt;
                        idx_nxt      = '0;
                        state_nxt    = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (idx == idx_last) begin
                        idx_nxt   = '0;
                        dcnt_nxt  = '0;
                        state_nxt = (LAT == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        idx_nxt = idx + MAC_IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DRAIN_LAST) state_nxt = ST_DONE;
                    else                    dcnt_nxt  = dcnt + 3'd1;
                end
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= SRC_FIR;
            last_srv <= SRC_LMS;
            idx      <= '0;
            dcnt     <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_srv <= last_srv_nxt;
            idx      <= idx_nxt;
            dcnt     <= dcnt_nxt;
            if (sample_tick && state != ST_IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_scheduler.sv
// Self-checking bench for mac_scheduler: directed tables, corner sequences and
// randomized traffic against a burst-queue reference model.
module tb_mac_scheduler;

    localparam int DIV_A = 450;
    localparam int NF    = 32;
    localparam int NL    = 16;
    localparam int LATC  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1, en = 1'b0, fir_req = 1'b0, lms_req = 1'b0;
    logic       sample_tick, fir_gnt, lms_gnt, mac_valid, mac_clr, mac_last;
    logic       fir_done, lms_done, overrun;
    logic [5:0] mac_idx;

    logic       reset40 = 1'b1, en40 = 1'b0, fir_req40 = 1'b0, lms_req40 = 1'b0;
    logic       sample_tick40, fir_gnt40, lms_gnt40, mac_valid40, mac_clr40, mac_last40;
    logic       fir_done40, lms_done40, overrun40;
    logic [5:0] mac_idx40;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_scheduler dut (
        .clk(clk), .reset(reset), .en(en), .sample_tick(sample_tick),
        .fir_req(fir_req), .lms_req(lms_req), .fir_gnt(fir_gnt), .lms_gnt(lms_gnt),
        .mac_valid(mac_valid), .mac_idx(mac_idx), .mac_clr(mac_clr), .mac_last(mac_last),
        .fir_done(fir_done), .lms_done(lms_done), .overrun(overrun)
    );

    mac_scheduler #(.DIV(40)) dut40 (
        .clk(clk), .reset(reset40), .en(en40), .sample_tick(sample_tick40),
        .fir_req(fir_req40), .lms_req(lms_req40), .fir_gnt(fir_gnt40), .lms_gnt(lms_gnt40),
        .mac_valid(mac_valid40), .mac_idx(mac_idx40), .mac_clr(mac_clr40), .mac_last(mac_last40),
        .fir_done(fir_done40), .lms_done(lms_done40), .overrun(overrun40)
    );

    // Reference model: a busy burst is a queue of per-enabled-cycle operations
    typedef struct packed {
        logic       issue;
        logic       done;
        logic [5:0] idx;
    } op_t;

    op_t mq[$];
    bit  m_busy, m_owner, m_last_srv, m_ovr;
    int  m_ecnt;

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_owner = 0; m_last_srv = 1; m_ovr = 0; m_ecnt = 0;
    endtask

    function automatic logic [14:0] model_out(input bit e);
        logic tk, fg, lg, v, c, l, fd, ld;
        logic [5:0] ix;
        op_t h;
        int n;
        tk = e && (m_ecnt == DIV_A - 1);
        fg = 0; lg = 0; v = 0; c = 0; l = 0; fd = 0; ld = 0; ix = '0;
        if (m_busy) begin
            h  = mq[0];
            n  = m_owner ? NL : NF;
            fg = !m_owner;
            lg = m_owner;
            v  = e && h.issue;
            ix = v ? h.idx : 6'd0;
            c  = v && (h.idx == 6'd0);
            l  = v && (int'(h.idx) == n - 1);
            fd = e && h.done && !m_owner;
            ld = e && h.done && m_owner;
        end
        return {tk, fg, lg, v, ix, c, l, fd, ld, m_ovr};
    endfunction

    task automatic model_step(input bit e, input bit fr, input bit lr, input bit rst);
        int n;
        if (rst) begin
            model_reset();
            return;
        end
        if (!e) return;
        if (m_ecnt == DIV_A - 1 && m_busy) m_ovr = 1;
        m_ecnt = (m_ecnt + 1) % DIV_A;
        if (m_busy) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_busy = 0;
        end else if (fr || lr) begin
            if (fr && lr) m_owner = !m_last_srv;
            else          m_owner = lr;
            m_last_srv = m_owner;
            n = m_owner ? NL : NF;
            for (int i = 0; i < n; i++) mq.push_back('{issue: 1'b1, done: 1'b0, idx: 6'(i)});
            for (int i = 0; i < LATC; i++) mq.push_back('{issue: 1'b0, done: 1'b0, idx: 6'd0});
            mq.push_back('{issue: 1'b0, done: 1'b1, idx: 6'd0});
            m_busy = 1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] pack_a();
        return {sample_tick, fir_gnt, lms_gnt, mac_valid, mac_idx, mac_clr, mac_last,
                fir_done, lms_done, overrun};
    endfunction

    task automatic cyc_a(input bit e, input bit fr, input bit lr, input bit rst, input string nm);
        @(negedge clk);
        en = e; fir_req = fr; lms_req = lr; reset = rst;
        #1;
        check(nm, 32'(pack_a()), 32'(model_out(e)));
        model_step(e, fr, lr, rst);
    endtask

    task automatic cyc_b(input bit e, input bit fr, input bit lr, input bit rst);
        @(negedge clk);
        en40 = e; fir_req40 = fr; lms_req40 = lr; reset40 = rst;
        #1;
    endtask

    typedef struct {
        bit fr;
        bit lr;
        bit exp_lms;
        int exp_issues;
        int exp_gnt;
    } row_t;

    row_t rows[7];

    initial begin
        int gf, gl, nv, clr_n, last_n, dw, dl, first, cnt, nld, nd;
        bit seen, ok, found, pf, pl;
        int ord[3];
        int dord[3];

        rows[0] = '{1, 0, 0, NF, NF + LATC + 1};
        rows[1] = '{1, 1, 1, NL, NL + LATC + 1};
        rows[2] = '{1, 1, 0, NF, NF + LATC + 1};
        rows[3] = '{0, 1, 1, NL, NL + LATC + 1};
        rows[4] = '{1, 1, 0, NF, NF + LATC + 1};
        rows[5] = '{1, 0, 0, NF, NF + LATC + 1};
        rows[6] = '{1, 1, 1, NL, NL + LATC + 1};

        @(negedge clk);
        reset = 1; en = 1;
        model_reset();

        // Idle divider run: ticks only on the 450th and 900th enabled cycles
        for (int i = 0; i < 1000; i++) begin
            cyc_a(1, 0, 0, 0, "idle_outputs");
            check("idle_tick", 32'(sample_tick), 32'((i == 449 || i == 899) ? 1 : 0));
        end

        // Single-burst table: request pattern -> winner, grant length, issues
        foreach (rows[r]) begin
            cyc_a(1, rows[r].fr, rows[r].lr, 0, "tbl_arb");
            gf = 0; gl = 0; nv = 0; clr_n = 0; last_n = 0; dw = 0; dl = 0;
            seen = 0; ok = 1;
            for (int k = 0; k < 100; k++) begin
                cyc_a(1, 0, 0, 0, "tbl_run");
                if (fir_gnt) gf++;
                if (lms_gnt) gl++;
                if (mac_valid) begin
                    if (int'(mac_idx) != nv) ok = 0;
                    nv++;
                end
                if (mac_clr) clr_n++;
                if (mac_last) last_n++;
                if (rows[r].exp_lms ? lms_done : fir_done) dw++;
                if (rows[r].exp_lms ? fir_done : lms_done) dl++;
                if (fir_gnt || lms_gnt) seen = 1;
                else if (seen) break;
            end
            check("tbl_gnt_len", 32'(rows[r].exp_lms ? gl : gf), 32'(rows[r].exp_gnt));
            check("tbl_other_gnt", 32'(rows[r].exp_lms ? gf : gl), 0);
            check("tbl_issues", 32'(nv), 32'(rows[r].exp_issues));
            check("tbl_idx_seq", 32'(ok), 1);
            check("tbl_clr_last", 32'({clr_n[15:0], last_n[15:0]}), 32'h0001_0001);
            check("tbl_done", 32'({dw[15:0], dl[15:0]}), 32'h0001_0000);
        end

        // Both requests held: FIR, LMS, FIR with alternating done pulses
        ord = '{-1, -1, -1}; dord = '{-1, -1, -1};
        cnt = 0; nd = 0; pf = 0; pl = 0;
        for (int k = 0; k < 200 && nd < 3; k++) begin
            cyc_a(1, 1, 1, 0, "held_run");
            if (fir_gnt && !pf && cnt < 3) begin ord[cnt] = 0; cnt++; end
            if (lms_gnt && !pl && cnt < 3) begin ord[cnt] = 1; cnt++; end
            if (fir_done) begin dord[nd] = 0; nd++; end
            else if (lms_done) begin dord[nd] = 1; nd++; end
            pf = fir_gnt; pl = lms_gnt;
        end
        cyc_a(1, 0, 0, 0, "held_release");
        check("held_order", 32'({ord[0][3:0], ord[1][3:0], ord[2][3:0]}), 32'h010);
        check("held_done_order", 32'({dord[0][3:0], dord[1][3:0], dord[2][3:0]}), 32'h010);

        // Stall for 5 cycles just before idx 10 of a FIR burst
        cyc_a(1, 1, 0, 0, "stall_arb");
        found = 0;
        for (int k = 0; k < 50; k++) begin
            cyc_a(1, 0, 0, 0, "stall_pre");
            if (mac_valid && mac_idx == 6'd9) begin found = 1; break; end
        end
        check("stall_reach_idx9", 32'(found), 1);
        for (int k = 0; k < 5; k++) begin
            cyc_a(0, 0, 0, 0, "stall_frozen");
            check("stall_hold", 32'({mac_valid, fir_gnt, fir_done, sample_tick}), 32'b0100);
        end
        first = -1; cnt = 0; ok = 1;
        for (int k = 0; k < 60; k++) begin
            cyc_a(1, 0, 0, 0, "stall_post");
            if (mac_valid) begin
                if (first < 0) first = int'(mac_idx);
                if (int'(mac_idx) != 10 + cnt) ok = 0;
                cnt++;
            end
            if (!fir_gnt) break;
        end
        check("stall_resume_idx", 32'(first), 10);
        check("stall_rest_issues", 32'(cnt), 22);
        check("stall_contiguous", 32'(ok), 1);

        // Randomized traffic with occasional stalls and resets
        for (int i = 0; i < 3000; i++) begin
            cyc_a($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 999) == 0, "rand");
        end

        // Reset in the middle of an LMS burst
        cyc_a(1, 0, 0, 1, "rst_pre");
        cyc_a(1, 0, 1, 0, "rst_lms_arb");
        found = 0; nld = 0;
        for (int k = 0; k < 40; k++) begin
            cyc_a(1, 0, 0, 0, "rst_lms_run");
            if (lms_done) nld++;
            if (lms_gnt && mac_valid && mac_idx == 6'd7) begin found = 1; break; end
        end
        check("rst_reach_idx7", 32'(found), 1);
        cyc_a(1, 0, 0, 1, "rst_mid");
        cyc_a(1, 0, 0, 0, "rst_after");
        check("rst_all_zero", 32'(pack_a()), 0);
        for (int k = 0; k < 40; k++) begin
            cyc_a(1, 0, 0, 0, "rst_quiet");
            if (lms_done) nld++;
        end
        check("rst_no_lms_done", 32'(nld), 0);
        cyc_a(1, 1, 1, 0, "rst_tie");
        cyc_a(1, 0, 0, 0, "rst_tie_gnt");
        check("rst_tie_fir", 32'({fir_gnt, lms_gnt}), 32'b10);

        // Short sample period: overrun sets at first tick inside a burst
        cyc_b(0, 0, 0, 1);
        for (int k = 0; k < 200; k++) begin
            cyc_b(1, 1, 1, 0);
            check("ovr40", 32'(overrun40), 32'((k >= 40) ? 1 : 0));
        end
        cyc_b(1, 1, 1, 1);
        cyc_b(1, 0, 0, 0);
        check("ovr40_cleared", 32'(overrun40), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_scheduler.md
MAC_SCHEDULER -- requirements
Module: mac_scheduler

Interface
REQ-001 SHALL have parameter DIV, default 450, meaning clk cycles per sample period (19.8 MHz / 450 = 44 kHz).
REQ-002 SHALL have parameter NTAPS_FIR, default 32, meaning MAC operations per FIR burst (range 1..64).
REQ-003 SHALL have parameter NTAPS_LMS, default 16, meaning MAC operations per LMS burst (range 1..64).
REQ-004 SHALL have parameter LAT, default 2, meaning shared-multiplier pipeline depth in cycles (range 0..7).
REQ-005 SHALL have port clk  input  1  system clock (19.8 MHz domain); one clock only.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  global clock enable; low stalls the block.
REQ-008 SHALL have port sample_tick  output  1  one-cycle pulse once per DIV enabled cycles.
REQ-009 SHALL have ports fir_req / lms_req  input  1 each  level request for one burst on the shared MAC.
REQ-010 SHALL have ports fir_gnt / lms_gnt  output  1 each  grant, held for the whole burst plus drain.
REQ-011 SHALL have port mac_valid  output  1  operand issue strobe to the shared MAC.
REQ-012 SHALL have port mac_idx  output  6  tap index of the current issue.
REQ-013 SHALL have ports mac_clr / mac_last  output  1 each  first / last issue of a burst.
REQ-014 SHALL have ports fir_done / lms_done  output  1 each  one-cycle burst-complete pulse.
REQ-015 SHALL have port overrun  output  1  sticky schedule-overrun flag.

Function
REQ-016 Tick counter SHALL count 0..DIV-1 on enabled cycles, wrap to 0, and pulse sample_tick in the cycle the count equals DIV-1.
REQ-017 FSM SHALL have states IDLE, BURST, DRAIN, DONE.
REQ-018 IDLE: on an enabled cycle with any req high, SHALL go to BURST and assert the winner's gnt from the next cycle.
REQ-019 Arbitration SHALL be round-robin: after reset FIR wins a tie; afterwards a tie goes to the requester not served last.
REQ-020 BURST: SHALL assert mac_valid for exactly N enabled cycles (N = NTAPS of the granted requester), with mac_idx = 0..N-1.
REQ-021 mac_clr SHALL be high with idx 0 only; mac_last SHALL be high with idx N-1 only; both high together when N = 1.
REQ-022 DRAIN SHALL last LAT enabled cycles with mac_valid low; when LAT = 0, DRAIN SHALL be skipped.
REQ-023 DONE SHALL last one cycle: pulse the granted requester's done, drop its gnt in the same cycle, then return to IDLE.
REQ-024 A req deasserted mid-burst SHALL NOT abort the burst; a req held high after done SHALL be re-arbitrated from IDLE.
REQ-025 en low SHALL freeze the tick counter, FSM, and index, and force mac_valid, sample_tick, and the done pulses low; gnt SHALL hold.
REQ-026 overrun SHALL set when sample_tick fires while the FSM is not IDLE, and SHALL clear only on reset.
REQ-027 mac_idx SHALL be 0 whenever mac_valid is low.

Reset
REQ-028 On reset, the block SHALL set the FSM to IDLE, the tick count to 0, and the round-robin pointer to favour FIR.
REQ-029 On reset, all outputs SHALL be 0.
REQ-030 Reset mid-burst SHALL abort the burst with no done pulse, taking effect at the next edge.

Structure
REQ-031 The FSM state encoding and the MAC index width constant (6) SHALL live in shared package filter_pkg.
REQ-032 The tick divider SHALL be the sub-module sample_tick_gen (parameter DIV; ports clk, reset, en, tick).
REQ-033 The arbiter and FSM SHALL stay in mac_scheduler.

Verification
REQ-034 Reset, en = 1, no req, 1000 cycles -> sample_tick at cycles 449 and 899 only; all other outputs 0.
REQ-035 fir_req pulse of 1 cycle from IDLE -> fir_gnt for 32 + 2 + 1 cycles; mac_idx 0..31; mac_clr at idx 0; mac_last at idx 31; fir_done once.
REQ-036 fir_req and lms_req both held high -> grants alternate FIR, LMS, FIR; lms burst issues idx 0..15; done pulses alternate.
REQ-037 en toggled low for 5 cycles at idx 10 -> idx resumes at 10 with no skipped or repeated issue; burst length unchanged.
REQ-038 DIV = 40, both requesters held high -> overrun sets at the first tick inside a burst and stays set; reset clears it.
REQ-039 reset asserted at lms idx 7 -> all outputs 0 next cycle; no lms_done; a following tie grants FIR.
